// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter.
// Holds the FSM state enum, default timing values and frame size.
// Also provides the odd-parity helper used when latching a command byte.
package ps2_pkg;

  // Default timing in system clocks at 10 MHz
  localparam int PS2_INHIBIT_CYCLES = 1200;   // 120 us clock-low inhibit
  localparam int PS2_REQ_CYCLES     = 20;     // 2 us data-low overlap
  localparam int PS2_FIRST_TIMEOUT  = 150000; // 15 ms wait for first device edge
  localparam int PS2_EDGE_TIMEOUT   = 2000;   // 200 us between later edges
  localparam int PS2_FRAME_BITS     = 11;     // start, 8 data, parity, stop
  localparam int PS2_TIMER_W        = 18;

  typedef logic [PS2_TIMER_W-1:0] timer_t;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_t;

  // Odd parity: the nine bits data+parity always hold an odd number of ones
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Purpose: bring one raw PS/2 line into the clock domain and flag its falling edges.
// Latency: line_sync lags the pin by 2 clocks; line_fall is valid the same cycle as line_sync.
// Backpressure: none, free-running observer of an asynchronous line.
module ps2_line_sync (
  input  logic clock,
  input  logic resetn,
  input  logic line_in,
  output logic line_sync,
  output logic line_fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

  // Shift chain: two metastability stages, then one stage of history for edge detect
  always_comb begin
    s1_d   = line_in;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  // Reset to the idle-high level so leaving reset never looks like a falling edge
  always_ff @(posedge clock) begin
    if (!resetn) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign line_sync = s2_q;
  assign line_fall = prev_q & ~s2_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Purpose: send one command byte to a PS/2 device via request-to-send and report its ACK.
// Latency: INHIBIT_CYCLES + REQ_CYCLES of bus request, then 11 device clocks plus a few cycles of line settling.
// Backpressure: tx_ready is high only in IDLE; tx_valid at any other time is dropped, nothing queues.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int REQ_CYCLES     = PS2_REQ_CYCLES,
  parameter int FIRST_TIMEOUT  = PS2_FIRST_TIMEOUT,
  parameter int EDGE_TIMEOUT   = PS2_EDGE_TIMEOUT
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       error
);

  // Timer compares against limit-1 so the registered action lands exactly limit cycles after entry
  localparam timer_t INH_LAST   = timer_t'(INHIBIT_CYCLES - 1);
  localparam timer_t REQ_LAST   = timer_t'(REQ_CYCLES - 1);
  localparam timer_t FIRST_LAST = timer_t'(FIRST_TIMEOUT - 1);
  localparam timer_t EDGE_LAST  = timer_t'(EDGE_TIMEOUT - 1);
  // bitcnt value seen on the fall that releases data for the stop bit (fall 10)
  localparam logic [3:0] STOP_IDX = 4'(PS2_FRAME_BITS - 2);

  ps2_tx_state_t state_q, state_d;
  timer_t        timer_q, timer_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [8:0]    shift_q, shift_d;
  logic          drive_q, drive_d;        // data_oe value while in SEND
  logic          ack_seen_q, ack_seen_d;  // ACK sampled on fall 11, published with done
  logic          ack_ok_q, ack_ok_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic clk_sync, clk_fall;
  logic data_sync, data_fall_unused;
  logic tmo;
  logic lines_idle;

  ps2_line_sync u_clk_sync (
    .clock     (clock),
    .resetn    (resetn),
    .line_in   (ps2_clk_in),
    .line_sync (clk_sync),
    .line_fall (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clock     (clock),
    .resetn    (resetn),
    .line_in   (ps2_data_in),
    .line_sync (data_sync),
    .line_fall (data_fall_unused)
  );

  assign lines_idle = clk_sync & data_sync;

  // Timeout detect: a device edge (or idle lines in WAIT_IDLE) on the limit cycle wins
  always_comb begin
    tmo = 1'b0;
    case (state_q)
      SEND:      tmo = ~clk_fall & (timer_q == ((bitcnt_q == 4'd0) ? FIRST_LAST : EDGE_LAST));
      ACK:       tmo = ~clk_fall & (timer_q == EDGE_LAST);
      WAIT_IDLE: tmo = ~lines_idle & (timer_q == EDGE_LAST);
      default:   tmo = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (tx_valid) state_d = INHIBIT;
      INHIBIT:   if (timer_q == INH_LAST) state_d = REQ;
      REQ:       if (timer_q == REQ_LAST) state_d = SEND;
      SEND: begin
        if (clk_fall) begin
          if (bitcnt_q == STOP_IDX) state_d = ACK;
        end else if (tmo) begin
          state_d = IDLE;
        end
      end
      ACK: begin
        if (clk_fall)  state_d = WAIT_IDLE;
        else if (tmo)  state_d = IDLE;
      end
      WAIT_IDLE: begin
        if (lines_idle) state_d = IDLE;
        else if (tmo)   state_d = IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

  // FSM outputs: open-drain enables and handshake flags decoded from state
  always_comb begin
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    case (state_q)
      INHIBIT: ps2_clk_oe = 1'b1;
      REQ: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
      end
      SEND:    ps2_data_oe = drive_q;
      default: ;
    endcase
  end

  assign tx_ready = (state_q == IDLE);
  assign busy     = ~tx_ready;
  assign done     = done_q;
  assign error    = error_q;
  assign ack_ok   = ack_ok_q;

  // Datapath next values: timer, bit counter, shift register, data drive and result flags
  always_comb begin
    timer_d    = (timer_q == '1) ? timer_q : timer_q + 1'b1;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    drive_d    = drive_q;
    ack_seen_d = ack_seen_q;
    ack_ok_d   = ack_ok_q;
    done_d     = 1'b0;
    error_d    = tmo;
    if (state_d != state_q) timer_d = '0;
    case (state_q)
      IDLE: begin
        drive_d = 1'b0;
        if (tx_valid) begin
          shift_d  = {odd_parity(tx_data), tx_data};
          bitcnt_d = 4'd0;
        end
      end
      REQ: begin
        // Start bit: data stays low into SEND until the first device fall
        drive_d  = 1'b1;
        bitcnt_d = 4'd0;
      end
      SEND: begin
        if (clk_fall) begin
          bitcnt_d = bitcnt_q + 1'b1;
          timer_d  = '0;
          if (bitcnt_q < STOP_IDX) drive_d = ~shift_q[bitcnt_q];
          else                     drive_d = 1'b0;
        end
      end
      ACK: begin
        drive_d = 1'b0;
        if (clk_fall) ack_seen_d = ~data_sync;
      end
      WAIT_IDLE: begin
        if (lines_idle) begin
          done_d   = 1'b1;
          ack_ok_d = ack_seen_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    if (!resetn) begin
      timer_q    <= '0;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      drive_q    <= 1'b0;
      ack_seen_q <= 1'b0;
      ack_ok_q   <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      drive_q    <= drive_d;
      ack_seen_q <= ack_seen_d;
      ack_ok_q   <= ack_ok_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

endmodule
